// File: rtl/fab_reset_sequencer_if.sv
// Signal bundle between the fabric reset sequencer and the surrounding device logic.
// The sequencer connects through the slave modport; the driving environment uses master.
interface fab_reset_sequencer_if;
    logic       fab_ccc_lock;
    logic       init_done;
    logic       mss_ready;
    logic       isp_req;
    logic       fab_reset_n;
    logic       fabric_rst_n;
    logic       isp_ack;
    logic       timeout_err;
    logic [2:0] seq_state;

    modport master (
        output fab_ccc_lock, init_done, mss_ready, isp_req,
        input  fab_reset_n, fabric_rst_n, isp_ack, timeout_err, seq_state
    );

    modport slave (
        input  fab_ccc_lock, init_done, mss_ready, isp_req,
        output fab_reset_n, fabric_rst_n, isp_ack, timeout_err, seq_state
    );
endinterface

// File: rtl/fab_reset_sequencer.sv
// Fabric reset sequencer: waits for filtered CCC lock and device/MSS readiness, releases the
// fabric after a delay, and quiesces the fabric on request so ISP can proceed safely.
module fab_reset_sequencer #(
    parameter int unsigned LOCK_FILTER    = 16,
    parameter int unsigned RELEASE_DELAY  = 64,
    parameter int unsigned QUIESCE_CYCLES = 32,
    parameter int unsigned INIT_TIMEOUT   = 1048576
) (
    input logic                  clk_base_i,
    input logic                  reset_i,
    fab_reset_sequencer_if.slave bus_io
);

    localparam int unsigned MaxRq  = (RELEASE_DELAY > QUIESCE_CYCLES) ? RELEASE_DELAY
                                                                      : QUIESCE_CYCLES;
    localparam int unsigned MaxCnt = (INIT_TIMEOUT > MaxRq) ? INIT_TIMEOUT : MaxRq;
    localparam int unsigned CntW   = $clog2(MaxCnt);
    localparam int unsigned LockW  = $clog2(LOCK_FILTER + 1);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StWaitLock   = 3'd1,
        StWaitInit   = 3'd2,
        StRelease    = 3'd3,
        StRun        = 3'd4,
        StIspQuiesce = 3'd5,
        StIspHold    = 3'd6,
        StFault      = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]       sync1_q, sync2_q;
    logic             fab_reset_n_q, fab_reset_n_d;
    logic             fabric_rst_n_q, fabric_rst_n_d;
    logic             isp_ack_q, isp_ack_d;
    logic             timeout_err_q, timeout_err_d;
    logic             lock_s, init_s, mss_s, isp_s;
    logic             locked_nxt;

    assign lock_s = sync2_q[0];
    assign init_s = sync2_q[1];
    assign mss_s  = sync2_q[2];
    assign isp_s  = sync2_q[3];

    // Lock filter; the transition fires on the edge where the count reaches LOCK_FILTER.
    always_comb begin
        lock_cnt_d = '0;
        if (lock_s) begin
            lock_cnt_d = (lock_cnt_q == LockW'(LOCK_FILTER)) ? lock_cnt_q
                                                              : lock_cnt_q + 1'b1;
        end
        locked_nxt = (lock_cnt_d == LockW'(LOCK_FILTER));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle:     state_d = StWaitLock;
            StWaitLock: if (locked_nxt) state_d = StWaitInit;
            StWaitInit: begin
                if (!lock_s)                           state_d = StWaitLock;
                else if (init_s && mss_s)              state_d = StRelease;
                else if (cnt_q == CntW'(INIT_TIMEOUT - 1)) state_d = StFault;
                else                                   cnt_d = cnt_q + 1'b1;
            end
            StRelease: begin
                if (!lock_s)                              state_d = StWaitLock;
                else if (cnt_q == CntW'(RELEASE_DELAY - 1)) state_d = StRun;
                else                                      cnt_d = cnt_q + 1'b1;
            end
            StRun: begin
                if (!lock_s)    state_d = StWaitLock;
                else if (isp_s) state_d = StIspQuiesce;
            end
            StIspQuiesce: begin
                // A withdrawn request wins over the quiesce count expiring in the same cycle.
                if (!lock_s)                               state_d = StWaitLock;
                else if (!isp_s)                           state_d = StRelease;
                else if (cnt_q == CntW'(QUIESCE_CYCLES - 1)) state_d = StIspHold;
                else                                       cnt_d = cnt_q + 1'b1;
            end
            StIspHold: begin
                if (!lock_s)     state_d = StWaitLock;
                else if (!isp_s) state_d = StRelease;
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change together with SEQ_STATE.
    always_comb begin
        fab_reset_n_d  = state_d inside {StWaitInit, StRelease, StRun, StIspQuiesce, StIspHold};
        fabric_rst_n_d = (state_d == StRun);
        isp_ack_d      = (state_d == StIspHold);
        timeout_err_d  = timeout_err_q | (state_d == StFault);
    end

    always_ff @(posedge clk_base_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            state_q        <= StIdle;
            cnt_q          <= '0;
            lock_cnt_q     <= '0;
            fab_reset_n_q  <= 1'b0;
            fabric_rst_n_q <= 1'b0;
            isp_ack_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            sync1_q        <= {bus_io.isp_req, bus_io.mss_ready, bus_io.init_done,
                               bus_io.fab_ccc_lock};
            sync2_q        <= sync1_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_cnt_q     <= lock_cnt_d;
            fab_reset_n_q  <= fab_reset_n_d;
            fabric_rst_n_q <= fabric_rst_n_d;
            isp_ack_q      <= isp_ack_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus_io.seq_state    = state_q;
    assign bus_io.fab_reset_n  = fab_reset_n_q;
    assign bus_io.fabric_rst_n = fabric_rst_n_q;
    assign bus_io.isp_ack      = isp_ack_q;
    assign bus_io.timeout_err  = timeout_err_q;

endmodule
